ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly upstream of the memory/branch stage.
- Accepts one operation from the decode/execute boundary and stalls the front of the pipeline while it computes.
- Its result is selected onto ex_mb__alu_y in place of the ALU result.
- Radix-2: one partial product or one quotient bit per cycle; special divide cases complete early.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- id_ex__muldiv_start  input  1  request: operation valid this cycle
- id_ex__muldiv_op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- id_ex__rs1_rdata  input  32  operand a
- id_ex__rs2_rdata  input  32  operand b
- ex_flush  input  1  kill in-flight operation (branch taken / trap)
- ex_muldiv__busy  output  1  registered; computation in progress
- ex_muldiv__stall  output  1  combinational; hold IF/ID/EX pipeline registers
- ex_muldiv__done  output  1  registered; single-cycle pulse, y valid
- ex_muldiv__y  output  32  result; held until the next accepted start

Behaviour:
- Reset (rst high at a clk edge): state IDLE; busy=0, done=0, y=0, counter=0. Same behaviour when rst is asserted mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge N:
  - Latch op.
  - Latch operand magnitudes (absolute values for signed operands; MULHSU: rs1 signed, rs2 unsigned).
  - Latch result-sign flags.
  - Clear accumulator; counter=0.
  - Go to CALC.
- IDLE, start=1, special divide case: go directly to DONE with y set at edge N.
  - Divide by zero (b==0): DIV/DIVU y=0xFFFFFFFF; REM/REMU y=a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV y=0x80000000, REM y=0.
- CALC:
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring divide producing one quotient bit per cycle into a 64-bit remainder:quotient register.
  - Counter increments each cycle; after count 31 go to FIX.
  - 32 cycles exactly.
- FIX:
  - Apply two's-complement negation per the sign flags. Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - Select the result: low word for MUL, high word for MULH/MULHSU/MULHU, quotient or remainder for divides.
  - Register the result into y; go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.
  - Normal latency: start sampled at edge N, done high in cycle N+34.
  - Special-case latency: done high in cycle N+1.
- busy: high in every cycle where state is CALC or FIX; low in IDLE and DONE.
- stall = (start & state==IDLE & ~flush) | busy.
  - Stall is low in the DONE cycle so the pipeline advances and EX/MB captures y.
  - A start in the DONE cycle is not accepted. Decode holds it one more cycle, so back-to-back operations are spaced at least 35 cycles apart.
- start while busy or in DONE: ignored; latched operands are unchanged.
- flush:
  - Synchronous; on the edge it is sampled, state goes to IDLE and busy=0.
  - No done pulse for the killed operation; y keeps its previous value.
  - flush and start in the same IDLE cycle: start is ignored.
  - flush in the DONE cycle: the done pulse still completes; state goes to IDLE.
- rst and flush together: rst wins (y cleared).
- Widths:
  - Magnitudes are 32-bit unsigned. |0x80000000| = 0x80000000 is represented correctly.
  - Product and remainder arithmetic are 64-bit and 33-bit respectively; no overflow inside CALC.
- Operand changes after acceptance have no effect on the result.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done at N+34, y=0xFFFFFFEB; busy high for cycles N+1..N+33.
- MULH a=0x80000000, b=0x80000000 -> y=0x40000000. MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> y=0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF -> y=0xFFFFFFFF.
- DIV a=-7, b=2 -> y=0xFFFFFFFD (-3). REM a=-7, b=2 -> y=0xFFFFFFFF (-1). DIVU a=100, b=7 -> y=14. REMU a=100, b=7 -> y=2.
- DIVU a=5, b=0 -> done at N+1, y=0xFFFFFFFF. REM a=5, b=0 -> y=5. DIV a=0x80000000, b=-1 -> y=0x80000000 at N+1.
- Start DIV, assert flush at N+10 -> busy=0 at N+11, no done pulse, y unchanged. Repeat with rst at N+10 -> y=0.
- Start pulsed again at N+5 with different operands -> ignored; stall stays high throughout; original result delivered at N+34.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative radix-2 RV32M multiply/divide for the execute stage; 34-cycle latency, 1 cycle for
// divide-by-zero / signed overflow. Stalls the front end while busy; starts outside IDLE are ignored.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_ex__muldiv_start,
  input  logic [2:0]      id_ex__muldiv_op,
  input  logic [XLEN-1:0] id_ex__rs1_rdata,
  input  logic [XLEN-1:0] id_ex__rs2_rdata,
  input  logic            ex_flush,
  output logic            ex_muldiv__busy,
  output logic            ex_muldiv__stall,
  output logic            ex_muldiv__done,
  output logic [XLEN-1:0] ex_muldiv__y
);

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] rq_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   y_q;

  logic              sa, sb, a_neg, b_neg, neg_d, is_div;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   spec_y_d;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] step_d, prod_fix;
  logic [XLEN-1:0]   res_d;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (id_ex__muldiv_op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin sa = 1'b1; sb = 1'b1; end
      OP_MULHSU:                       sa = 1'b1;
      default: ;
    endcase
    a_neg  = sa & id_ex__rs1_rdata[XLEN-1];
    b_neg  = sb & id_ex__rs2_rdata[XLEN-1];
    a_mag  = a_neg ? (XLEN'(0) - id_ex__rs1_rdata) : id_ex__rs1_rdata;
    b_mag  = b_neg ? (XLEN'(0) - id_ex__rs2_rdata) : id_ex__rs2_rdata;
    is_div = id_ex__muldiv_op[2];
    unique case (id_ex__muldiv_op)
      OP_MUL, OP_MULH, OP_DIV: neg_d = a_neg ^ b_neg;
      OP_MULHSU, OP_REM:       neg_d = a_neg;
      default:                 neg_d = 1'b0;
    endcase
    div_zero = is_div && (id_ex__rs2_rdata == '0);
    div_ovf  = is_div && !id_ex__muldiv_op[0] && (id_ex__rs1_rdata == INT_MIN) && (id_ex__rs2_rdata == '1);
    if (div_zero) spec_y_d = id_ex__muldiv_op[1] ? id_ex__rs1_rdata : '1;
    else          spec_y_d = id_ex__muldiv_op[1] ? '0 : INT_MIN;
  end

  // Shared 64-bit register: {product hi, multiplier} for multiply, {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, rq_q[2*XLEN-1:XLEN]} + (rq_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = rq_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    if (op_q[2])
      step_d = div_trial[XLEN] ? {rq_q[2*XLEN-2:0], 1'b0}
                               : {div_trial[XLEN-1:0], rq_q[XLEN-2:0], 1'b1};
    else
      step_d = {mul_sum, rq_q[XLEN-1:1]};
  end

  always_comb begin
    prod_fix = neg_q ? ((2*XLEN)'(0) - rq_q) : rq_q;
    unique case (op_q)
      OP_MUL:                      res_d = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             res_d = neg_q ? (XLEN'(0) - rq_q[XLEN-1:0]) : rq_q[XLEN-1:0];
      default:                     res_d = neg_q ? (XLEN'(0) - rq_q[2*XLEN-1:XLEN]) : rq_q[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      rq_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
    end else if (ex_flush) begin
      // A flush in DONE lands in IDLE exactly as the normal exit does.
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (id_ex__muldiv_start) begin
            op_q   <= id_ex__muldiv_op;
            neg_q  <= neg_d;
            cnt_q  <= '0;
            opnd_q <= is_div ? b_mag : a_mag;
            rq_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            if (div_zero || div_ovf) begin
              y_q     <= spec_y_d;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rq_q  <= step_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          y_q     <= res_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ex_muldiv__busy  = busy_q;
  assign ex_muldiv__done  = done_q;
  assign ex_muldiv__y     = y_q;
  assign ex_muldiv__stall = (id_ex__muldiv_start & (state_q == S_IDLE) & ~ex_flush) | busy_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: arithmetic results, latency, busy/stall timing, flush and reset kill.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        busy, stall, done;
  logic [31:0] y;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_y;

  ex_muldiv #(.XLEN(32), .CNT_W(5)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .id_ex__muldiv_start (start),
    .id_ex__muldiv_op    (op),
    .id_ex__rs1_rdata    (rs1),
    .id_ex__rs2_rdata    (rs2),
    .ex_flush            (flush),
    .ex_muldiv__busy     (busy),
    .ex_muldiv__stall    (stall),
    .ex_muldiv__done     (done),
    .ex_muldiv__y        (y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one op; samples land 1ns after each edge, cycle k being the one after edge N+k-1.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_y, input int exp_lat);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    #1 chk({tag, "_stall_req"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom;
    cyc = 1; busy_cnt = 0;
    while (!done && cyc < 60) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_y"}, y, exp_y);
    chk({tag, "_busycnt"}, 32'(busy_cnt), (exp_lat == 1) ? 32'd0 : 32'd33);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    last_y = exp_y;
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  // Start a DIV, then kill it with flush or reset during cycle N+10.
  task automatic kill_op(input string tag, input logic use_rst);
    int seen;
    @(negedge clk);
    start = 1'b1; op = 3'b100; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 2; i <= 10; i++) begin @(posedge clk); #1; end
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    chk({tag, "_nodone"}, 32'(seen), 32'd0);
    if (use_rst) last_y = 32'd0;
    chk({tag, "_y"}, y, last_y);
  endtask

  initial begin
    int cyc;
    int stall_lo;
    rst = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; flush = 1'b0;
    last_y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       34);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        34);
    run_op("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    kill_op("flush", 1'b0);
    kill_op("rstmid", 1'b1);

    // Start together with flush in IDLE is dropped.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b000; rs1 = 32'd3; rs2 = 32'd3;
    #1 chk("fs_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("fs_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("fs_done", 32'(done), 32'd0);

    // A second start mid-operation must not disturb the first.
    @(negedge clk);
    start = 1'b1; op = 3'b000; rs1 = 32'd7; rs2 = 32'hFFFFFFFD;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; stall_lo = 0;
    while (!done && cyc < 60) begin
      if (cyc == 5) begin start = 1'b1; op = 3'b101; rs1 = 32'd9; rs2 = 32'd3; end
      else start = 1'b0;
      #1 if (!stall) stall_lo++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("ign_stall", 32'(stall_lo), 32'd0);
    chk("ign_lat", 32'(cyc), 32'd34);
    chk("ign_y", y, 32'hFFFFFFEB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
